// File: rtl/ble_rx_pkg.sv
// Shared definitions for the BLE receive packet controller: FSM encoding,
// well-known constants, FIFO entry layout and small helper functions.
package ble_rx_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEARCH  = 3'd1;
    localparam logic [2:0] ST_HEADER  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CRC     = 3'd4;

    localparam logic [31:0] BLE_ADV_AA = 32'h8E89BED6;
    localparam logic [23:0] CRC_POLY   = 24'h00065B;
    localparam logic [23:0] CRC_INIT   = 24'h555555;

    // FIFO entry: {last, data}
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'b00000, v[i]};
        end
        return cnt;
    endfunction

    // One bit of the BLE CRC24 LFSR, MSB is the feedback tap
    function automatic logic [23:0] crc24_step(input logic [23:0] c, input logic b);
        logic [23:0] n;
        n = {c[22:0], 1'b0};
        if (c[23] ^ b) begin
            n = n ^ CRC_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/ble_byte_fifo.sv
// Synchronous byte FIFO with a last-byte flag per entry. Head entry is read
// straight from the storage registers; push while full succeeds only when a
// pop happens in the same cycle.
module ble_byte_fifo
    import ble_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  fifo_entry_t i_wdata,
    input  logic        i_pop,
    output fifo_entry_t o_rdata,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_en;
    logic        w_rd_en;

    // Write/read enables and flags from the extended-pointer comparison
    always_comb begin
        o_empty = (r_wr_ptr == r_rd_ptr);
        o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_rd_en = i_pop && !o_empty;
        w_wr_en = i_push && (!o_full || w_rd_en);
        o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    end

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ble_rx_packet_ctrl.sv
// BLE receive packet controller: turns the demodulated bit stream into bytes.
// Finds the access address, frames header/payload/CRC and queues bytes in a
// FIFO. Optional CRC24 checking is built when CRC_CHECK_EN is defined.
module ble_rx_packet_ctrl
    import ble_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned MAX_PDU_LEN = 37,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] access_addr,
    input  logic [2:0]  aa_tol,
    input  logic        update,
    input  logic        value,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic        pkt_abort,
    output logic        overflow,
    output logic        crc_ok,
    output logic [2:0]  state
);

    localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     MAX_LEN = 8'(MAX_PDU_LEN);

    logic [2:0]      r_state;
    logic            r_update_q;
    logic [31:0]     r_sr;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_byte_cnt;
    logic [7:0]      r_len;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_pkt_start;
    logic            r_pkt_done;
    logic            r_pkt_abort;
    logic            r_overflow;

    logic            w_bit_evt;
    logic [31:0]     w_sr_next;
    logic [7:0]      w_byte_next;
    logic            w_in_pkt;
    logic            w_timeout;
    logic            w_aa_hit;
    logic            w_push;
    logic            w_pop;
    fifo_entry_t     w_push_entry;
    fifo_entry_t     w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    // Bit-event detection, shift candidates and byte-completion decode
    always_comb begin
        w_bit_evt         = update & ~r_update_q;
        w_sr_next         = {value, r_sr[31:1]};
        w_byte_next       = {value, r_shift[7:1]};
        w_in_pkt          = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) ||
                            (r_state == ST_CRC);
        w_timeout         = w_in_pkt && !w_bit_evt && (r_to_cnt == TO_LAST);
        w_aa_hit          = popcount32(w_sr_next ^ access_addr) <= {3'b000, aa_tol};
        w_push            = enable && w_in_pkt && w_bit_evt && (r_bit_cnt == 3'd7);
        w_push_entry.last = (r_state == ST_CRC) && (r_byte_cnt == 8'd2);
        w_push_entry.data = w_byte_next;
        w_pop             = byte_ready && !w_fifo_empty;
    end

    ble_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Packet sequencing FSM, timeout counter and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_update_q  <= 1'b0;
            r_sr        <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_to_cnt    <= '0;
            r_pkt_start <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_abort <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_update_q  <= update;
            r_pkt_start <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_abort <= 1'b0;
            if (!enable) begin
                r_state    <= ST_IDLE;
                r_overflow <= 1'b0;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_to_cnt   <= '0;
            end else begin
                if (w_push && w_fifo_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
                if (w_in_pkt && !w_bit_evt) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end else begin
                    r_to_cnt <= '0;
                end
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SEARCH;
                        r_sr    <= '0;
                    end
                    ST_SEARCH: begin
                        if (w_bit_evt) begin
                            r_sr <= w_sr_next;
                            if (w_aa_hit) begin
                                r_state     <= ST_HEADER;
                                r_pkt_start <= 1'b1;
                                r_bit_cnt   <= '0;
                                r_byte_cnt  <= '0;
                            end
                        end
                    end
                    ST_HEADER, ST_PAYLOAD, ST_CRC: begin
                        if (w_timeout) begin
                            r_pkt_abort <= 1'b1;
                            r_state     <= ST_SEARCH;
                            r_sr        <= '0;
                            r_bit_cnt   <= '0;
                            r_byte_cnt  <= '0;
                        end else if (w_bit_evt) begin
                            r_shift   <= w_byte_next;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 3'd7) begin
                                r_byte_cnt <= r_byte_cnt + 1'b1;
                                if (r_state == ST_HEADER && r_byte_cnt == 8'd1) begin
                                    r_byte_cnt <= '0;
                                    r_len      <= w_byte_next;
                                    if (w_byte_next > MAX_LEN) begin
                                        r_pkt_abort <= 1'b1;
                                        r_state     <= ST_SEARCH;
                                        r_sr        <= '0;
                                    end else if (w_byte_next == 8'd0) begin
                                        r_state <= ST_CRC;
                                    end else begin
                                        r_state <= ST_PAYLOAD;
                                    end
                                end else if (r_state == ST_PAYLOAD &&
                                             r_byte_cnt == r_len - 8'd1) begin
                                    r_byte_cnt <= '0;
                                    r_state    <= ST_CRC;
                                end else if (r_state == ST_CRC && r_byte_cnt == 8'd2) begin
                                    r_byte_cnt <= '0;
                                    r_pkt_done <= 1'b1;
                                    r_state    <= ST_SEARCH;
                                    r_sr       <= '0;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CRC_CHECK_EN
    logic [23:0] r_crc;
    logic        r_crc_err;
    logic        r_crc_ok;
    logic        w_crc_mis;

    assign w_crc_mis = value ^ r_crc[23];

    // LFSR runs over header+payload; received CRC bits are checked against its MSB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc     <= CRC_INIT;
            r_crc_err <= 1'b0;
            r_crc_ok  <= 1'b0;
        end else if (enable && w_bit_evt) begin
            if (r_state == ST_SEARCH && w_aa_hit) begin
                r_crc     <= CRC_INIT;
                r_crc_err <= 1'b0;
                r_crc_ok  <= 1'b0;
            end else if (r_state == ST_HEADER || r_state == ST_PAYLOAD) begin
                r_crc <= crc24_step(r_crc, value);
            end else if (r_state == ST_CRC) begin
                r_crc <= {r_crc[22:0], 1'b0};
                if (w_crc_mis) begin
                    r_crc_err <= 1'b1;
                end
                if (r_bit_cnt == 3'd7 && r_byte_cnt == 8'd2) begin
                    r_crc_ok <= ~(r_crc_err | w_crc_mis);
                end
            end
        end
    end

    assign crc_ok = r_crc_ok;
`else
    assign crc_ok = 1'b0;
`endif

    assign byte_data  = w_head.data;
    assign byte_last  = w_head.last;
    assign byte_valid = !w_fifo_empty;
    assign pkt_start  = r_pkt_start;
    assign pkt_done   = r_pkt_done;
    assign pkt_abort  = r_pkt_abort;
    assign overflow   = r_overflow;
    assign state      = r_state;

endmodule
